// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM between requesters.
// Optional burst lock: define BRAM_ARB_LOCK_EN.
module bram_rr_arbiter #(
  parameter int NUM_REQ    = 3,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8192,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_wr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          bram_wr_en,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [DATA_WIDTH-1:0]         bram_din,
  input  logic [DATA_WIDTH-1:0]         bram_dout
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [PW-1:0]         rd_own_q, rd_own_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] din_q;

  logic                  win_v;
  logic [PW-1:0]         win;
  logic [PW-1:0]         cand;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_din;
  logic                  sel_wr;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'((v >= NUM_REQ) ? v - NUM_REQ : v);
  endfunction

`ifdef BRAM_ARB_LOCK_EN
  logic          lock_v_q, lock_v_d;
  logic [PW-1:0] lock_own_q, lock_own_d;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
`endif

  // Pick the winner: first requester at or above rr_ptr, wrapping.
  always_comb begin
    win_v = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = wrap(int'(rr_ptr_q) + k);
      if (!win_v && req[cand]) begin
        win_v = 1'b1;
        win   = cand;
      end
    end
`ifdef BRAM_ARB_LOCK_EN
    if (lock_v_q && req[lock_own_q]) begin
      win_v = 1'b1;
      win   = lock_own_q;
    end
`endif
    if (!rst_n) win_v = 1'b0;
  end

  // Select the winner's request fields and compute next state.
  always_comb begin
    sel_addr  = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
    sel_din   = req_wdata[win*DATA_WIDTH +: DATA_WIDTH];
    sel_wr    = req_wr[win];
    rr_ptr_d  = rr_ptr_q;
    if (win_v) begin
      rr_ptr_d = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
    rd_pend_d = win_v & ~sel_wr;
    rd_own_d  = win;
`ifdef BRAM_ARB_LOCK_EN
    lock_v_d   = win_v & req_lock[win];
    lock_own_d = win;
`endif
  end

  // Arbitration state, read tracking and idle hold of the BRAM bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      rd_own_q  <= '0;
      addr_q    <= '0;
      din_q     <= '0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_own_q  <= rd_own_d;
      if (win_v) begin
        addr_q <= sel_addr;
        din_q  <= sel_din;
      end
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  // Burst lock owner, cleared on reset or any non-locking cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lock_v_q   <= 1'b0;
      lock_own_q <= '0;
    end else begin
      lock_v_q   <= lock_v_d;
      lock_own_q <= lock_own_d;
    end
  end
`endif

  // Drive grant, BRAM port and read return; all quiet during reset.
  always_comb begin
    gnt        = win_v ? (NUM_REQ'(1) << win) : '0;
    bram_wr_en = win_v & sel_wr;
    bram_addr  = win_v ? sel_addr : addr_q;
    bram_din   = win_v ? sel_din : din_q;
    rvalid     = '0;
    rdata      = '0;
    if (!rst_n) begin
      bram_addr = '0;
      bram_din  = '0;
    end else if (rd_pend_q) begin
      rvalid = NUM_REQ'(1) << rd_own_q;
      rdata  = bram_dout;
    end
  end

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Scoreboard bench for bram_rr_arbiter with a BRAM model.
// Reference model follows the lock rules when BRAM_ARB_LOCK_EN is set.
module tb_bram_rr_arbiter;

  localparam int N  = 3;
  localparam int DW = 32;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, req_wr, req_lock;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]  gnt, rvalid;
  logic [DW-1:0] rdata;
  logic          bram_wr_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  always #5 clk = ~clk;

  bram_rr_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .DEPTH(8192)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req(req), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_lock(req_lock),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .bram_wr_en(bram_wr_en), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
    bram_dout = '0;
  end
  always @(posedge clk) begin
    if (bram_wr_en) mem[bram_addr] <= bram_din;
    bram_dout <= mem[bram_addr];
  end

  typedef struct {
    logic [N-1:0]  gnt;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
  } drv_t;
  typedef struct {
    int            cyc;
    int            own;
    logic [DW-1:0] data;
  } rd_t;

  drv_t gq[$];
  rd_t  rq[$];
  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  int            ptr;
  bit            lk_v;
  int            lk_own;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_din;
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  int            win;

  bit            s_req [N];
  bit            s_wr  [N];
  bit            s_lock[N];
  logic [AW-1:0] s_addr[N];
  logic [DW-1:0] s_wd  [N];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d actual=%h required=%h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic step(input bit rst);
    drv_t e;
    logic [AW-1:0] a;
    int j;
    @(negedge clk);
    cyc++;
    rst_n = !rst;
    for (int i = 0; i < N; i++) begin
      req[i]      = s_req[i];
      req_wr[i]   = s_wr[i];
      req_lock[i] = s_lock[i];
      req_addr[i*AW +: AW]  = s_addr[i];
      req_wdata[i*DW +: DW] = s_wd[i];
    end
    e = '{gnt: '0, we: 1'b0, addr: '0, din: '0};
    win = -1;
    if (rst) begin
      ptr = 0;
      lk_v = 0;
      last_addr = '0;
      last_din = '0;
      rq.delete();
    end else begin
`ifdef BRAM_ARB_LOCK_EN
      if (lk_v && s_req[lk_own]) win = lk_own;
`endif
      if (win < 0) begin
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (s_req[j]) begin
            win = j;
            break;
          end
        end
      end
      if (win >= 0) begin
        a = s_addr[win];
        e.gnt  = N'(1) << win;
        e.we   = s_wr[win];
        e.addr = a;
        e.din  = s_wd[win];
        last_addr = a;
        last_din  = s_wd[win];
        ptr    = (win + 1) % N;
        lk_v   = s_lock[win];
        lk_own = win;
        if (s_wr[win]) ref_mem[a] = s_wd[win];
        else rq.push_back('{cyc + 1, win,
          ref_mem.exists(a) ? ref_mem[a] : '0});
      end else begin
        e.addr = last_addr;
        e.din  = last_din;
        lk_v   = 0;
      end
    end
    gq.push_back(e);
  endtask

  initial begin
    drv_t e;
    rd_t  r;
    forever begin
      @(negedge clk);
      #2;
      if (gq.size() != 0) begin
        e = gq.pop_front();
        chk("gnt", 64'(gnt), 64'(e.gnt));
        chk("wr_en", 64'(bram_wr_en), 64'(e.we));
        chk("addr", 64'(bram_addr), 64'(e.addr));
        chk("din", 64'(bram_din), 64'(e.din));
        if (rq.size() != 0 && rq[0].cyc == cyc) begin
          r = rq.pop_front();
          chk("rvalid", 64'(rvalid), 64'(N'(1) << r.own));
          chk("rdata", 64'(rdata), 64'(r.data));
        end else begin
          chk("rvalid_idle", 64'(rvalid), 64'(0));
          chk("rdata_idle", 64'(rdata), 64'(0));
        end
      end
    end
  end

  task automatic clr();
    for (int i = 0; i < N; i++) begin
      s_req[i]  = 0;
      s_wr[i]   = 0;
      s_lock[i] = 0;
    end
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    s_req[i]  = 1;
    s_wr[i]   = 0;
    s_addr[i] = a;
  endtask

  initial begin
    int beats;
    bit rst;
    rst_n = 1'b0;
    req = '0; req_wr = '0; req_lock = '0;
    req_addr = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      s_addr[i] = '0;
      s_wd[i]   = '0;
    end
    clr();
    ptr = 0; lk_v = 0; lk_own = 0;
    last_addr = '0; last_din = '0;

    step(1); step(1);
    repeat (5) step(0);

    // fairness: all read their own id
    for (int n = 0; n < 9; n++) begin
      for (int i = 0; i < N; i++) set_rd(i, AW'(i));
      step(0);
    end
    clr(); step(0);

    // write then read same address
    s_req[0] = 1; s_wr[0] = 1;
    s_addr[0] = 13'h010; s_wd[0] = 32'hDEADBEEF;
    step(0);
    set_rd(0, 13'h010);
    step(0);
    clr(); step(0); step(0);

    // wrap and skip from rr_ptr=2
    set_rd(1, 13'h001); step(0);
    set_rd(0, 13'h010); set_rd(1, 13'h001);
    step(0);
    s_req[win] = 0;
    step(0);
    clr(); set_rd(2, 13'h002); step(0);
    clr(); step(0);

    // reset during a read
    set_rd(0, 13'h010); step(0);
    clr(); step(1);
    step(0);
    for (int i = 0; i < N; i++) set_rd(i, AW'(i));
    step(0);
    clr(); step(0); step(0);

    // burst lock from requester 1
    set_rd(0, 13'h000); step(0);
    for (int i = 0; i < N; i++) set_rd(i, AW'(i));
    beats = 0;
    for (int n = 0; n < 8; n++) begin
      s_lock[1] = (beats < 3);
      step(0);
      if (win == 1) begin
        beats++;
        s_req[1] = (beats < 4);
      end else if (win >= 0) begin
        s_req[win] = 0;
      end
    end
    clr(); step(0); step(0);

    // random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!s_req[i] && ($urandom % 4 != 0)) begin
          s_req[i]  = 1;
          s_wr[i]   = $urandom % 2;
          s_addr[i] = AW'($urandom % 16);
          s_wd[i]   = $urandom;
          s_lock[i] = ($urandom % 3 == 0);
        end
      end
      rst = ($urandom % 64 == 0);
      step(rst);
      if (win >= 0) s_req[win] = 0;
    end
    clr();
    repeat (3) step(0);
    @(negedge clk);
    #4;
    chk("drain", 64'(rq.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/bram_rr_arbiter.md
Name: bram_rr_arbiter

Overview:
Shares one single-port, 1-cycle-read-latency BRAM (DATA_WIDTH x DEPTH) among NUM_REQ matrix-engine requesters, e.g. loader, compute core and UART dump.
- Issues at most one access per cycle to the BRAM.
- Arbitrates round-robin.
- Routes returned read data back to the owning requester with a valid strobe.
- Sits between the requesters and the BRAM instance.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
DATA_WIDTH, 32, BRAM word width
DEPTH, 8192, BRAM word count
ADDR_WIDTH, $clog2(DEPTH), BRAM address width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
req  in  NUM_REQ  per-requester access request, held until granted
req_wr  in  NUM_REQ  1 = write, 0 = read, per requester
req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses, requester i in slice i
req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data
req_lock  in  NUM_REQ  burst lock request (used only with BRAM_ARB_LOCK_EN)
gnt  out  NUM_REQ  one-hot; access of requester i issued this cycle
rvalid  out  NUM_REQ  one-hot; rdata valid for requester i
rdata  out  DATA_WIDTH  read data, broadcast to all requesters
bram_wr_en  out  1  to BRAM wr_en
bram_addr  out  ADDR_WIDTH  to BRAM addr
bram_din  out  DATA_WIDTH  to BRAM din
bram_dout  in  DATA_WIDTH  from BRAM dout

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - rr_ptr=0, lock_owner invalid, rd_pending=0.
  - Outputs: gnt=0, rvalid=0, rdata=0.
  - bram_wr_en=0, bram_addr=0, bram_din=0.
  - Any in-flight read is squashed; no rvalid follows reset.
- Grant (combinational, same cycle as req):
  - Search starts at rr_ptr and goes upward with wrap NUM_REQ-1 -> 0; first i with req[i]=1 wins.
  - gnt is one-hot or zero; gnt=0 when req=0.
- BRAM drive:
  - When gnt[i]=1: bram_addr=req_addr[i], bram_din=req_wdata[i], bram_wr_en=req_wr[i].
  - When idle: bram_wr_en=0; addr and din hold their last value (no toggling).
- Requester handshake:
  - Access completes at the posedge where gnt[i]=1.
  - Requester may change req, addr, data or drop req afterwards; req held without gnt must stay stable.
- rr_ptr update: on any grant to i, rr_ptr <= (i+1) mod NUM_REQ at next posedge; unchanged when idle.
- Read return:
  - Grant of a read at cycle T registers rd_pending=1 and owner=i.
  - At T+1, when bram_dout holds the data: rvalid[i]=1 and rdata=bram_dout.
  - rdata is combinationally passed from bram_dout; it is 0 when no rvalid.
  - Back-to-back reads from any mix of requesters give one rvalid per cycle, in grant order.
- Writes produce no rvalid.
- Read-after-write, same address:
  - Write granted at T, read granted at T+1: the read returns the new data at T+2, since BRAM write and read are on different cycles.
  - Same-cycle read and write is impossible (single grant).
- Fairness: with all NUM_REQ requesting continuously, each is granted exactly once per NUM_REQ cycles.
- Starvation bound without lock: any held req is granted within NUM_REQ cycles.
- Reset mid-operation: all state cleared as above; requests present on the first cycle after reset are arbitrated from rr_ptr=0.

Optional Feature:
Macro BRAM_ARB_LOCK_EN.
- Defined:
  - If granted requester i has req_lock[i]=1, lock_owner <= i.
  - While lock_owner=i and req[i]=1, only i is granted and rr_ptr is frozen.
  - Lock releases at the first posedge where req[i]=0 or req_lock[i]=0 at grant; rr_ptr then advances to i+1 normally.
  - Intended for matrix row bursts.
  - Reset clears the lock.
- Undefined: req_lock is ignored, no lock state is synthesized, pure round-robin.

Test Plan:
- Idle after reset: req=000 for 5 cycles -> gnt=000, rvalid=000, bram_wr_en=0, rdata=0.
- Single write then read: req0 writes addr 0x010 data 0xDEADBEEF at T, then reads addr 0x010 at T+1 -> gnt0 at T and T+1, bram_wr_en=1 at T, rvalid[0]=1 at T+2 with rdata=0xDEADBEEF.
- Fairness: req=111, all reads of addr = requester id, for 9 cycles -> gnt sequence 001,010,100 repeated 3 times; rvalid follows one cycle later with the matching owner.
- Wrap and skip: rr_ptr=2 and req=011 -> gnt=001, then gnt=010; req[2]=1 alone the next cycle -> gnt=100 immediately.
- Reset mid-read: read granted at T, rst_n=0 at T+1 -> rvalid stays 000 at T+1 and T+2, rr_ptr=0 after reset.
- With BRAM_ARB_LOCK_EN: req1 with lock for 4 beats while req0 and req2 request -> gnt=010 for 4 cycles, then gnt=100, then 001. Without the macro, the same stimulus gives the plain round-robin rotation.
